// File: rtl/id_ex_shift_operand_pkg.sv
// Shared constants and helpers for the ID/EX shift-operand stage.
// ALU function encodings, shift-group decode and the per-edge register action.
package id_ex_shift_operand_pkg;

  localparam int W_DEF     = 32;
  localparam int RA_W_DEF  = 5;
  localparam int FUN_W_DEF = 6;

  localparam logic [5:0] ALU_SLL   = 6'b100000;
  localparam logic [5:0] ALU_SRL   = 6'b100001;
  localparam logic [5:0] ALU_SRA   = 6'b100011;
  localparam logic [1:0] SHIFT_GRP = 2'b10;
  localparam logic [4:0] REG_ZERO  = 5'd0;

  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_STALL = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_RESET = 2'd3
  } ex_act_e;

  function automatic logic is_shift(input logic [5:0] fun);
    return (fun[5:4] == SHIFT_GRP);
  endfunction

endpackage

// File: rtl/id_ex_shift_operand_fwd_sel.sv
// Forwarding mux for one source operand: EX/MEM beats MEM/WB, register 0 never forwards.
// Forwarding is present only when EX_FORWARD_EN is defined; otherwise the regfile value passes through.
module id_ex_shift_operand_fwd_sel
  import id_ex_shift_operand_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] idx,
  input  logic [W-1:0]    regval,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic [W-1:0]    exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic [W-1:0]    memwb_result,
  output logic [W-1:0]    value
);

`ifdef EX_FORWARD_EN
  // Priority select: youngest producer first, index 0 stays the regfile value.
  always_comb begin
    value = regval;
    if (idx != RA_W'(REG_ZERO)) begin
      if (exmem_reg_write && (exmem_rd == idx)) begin
        value = exmem_result;
      end else if (memwb_reg_write && (memwb_rd == idx)) begin
        value = memwb_result;
      end else begin
        value = regval;
      end
    end else begin
      value = regval;
    end
  end
`else
  assign value = regval;

  logic unused_fwd;
  assign unused_fwd = ^{idx, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
`endif

endmodule

// File: rtl/id_ex_shift_operand.sv
// ID/EX pipeline register and operand selector feeding ALU_SHIFT/ALU.
// Optional forwarding from EX/MEM and MEM/WB is enabled by defining EX_FORWARD_EN.
module id_ex_shift_operand
  import id_ex_shift_operand_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int FUN_W = FUN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [W-1:0]     id_rs_data,
  input  logic [W-1:0]     id_rt_data,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic [4:0]       id_shamt,
  input  logic [15:0]      id_imm,
  input  logic [FUN_W-1:0] id_alu_fun,
  input  logic             id_shamt_src,
  input  logic             id_alu_src_imm,
  input  logic             id_ext_op,
  input  logic             id_reg_write,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [W-1:0]     exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [W-1:0]     memwb_result,
  output logic             ex_valid,
  output logic [W-1:0]     ex_a,
  output logic [W-1:0]     ex_b,
  output logic             ex_right,
  output logic             ex_sign,
  output logic [FUN_W-1:0] ex_alu_fun,
  output logic [RA_W-1:0]  ex_rd,
  output logic             ex_reg_write
);

  ex_act_e          act;
  logic             valid_r;
  logic [W-1:0]     rs_val_r;
  logic [W-1:0]     rt_val_r;
  logic [RA_W-1:0]  rs_addr_r;
  logic [RA_W-1:0]  rt_addr_r;
  logic [RA_W-1:0]  rd_r;
  logic [4:0]       shamt_r;
  logic [15:0]      imm_r;
  logic [FUN_W-1:0] alu_fun_r;
  logic             shamt_src_r;
  logic             alu_src_imm_r;
  logic             ext_op_r;
  logic             reg_write_r;
  logic [W-1:0]     fwd_rs;
  logic [W-1:0]     fwd_rt;
  logic [W-1:0]     imm_ext;
  logic             shift_grp;

  // Per-edge action in priority order.
  always_comb begin
    act = ACT_LOAD;
    if (reset) begin
      act = ACT_RESET;
    end else if (flush) begin
      act = ACT_FLUSH;
    end else if (stall) begin
      act = ACT_STALL;
    end else begin
      act = ACT_LOAD;
    end
  end

  // Pipeline register. A stalled slot reloads its operands with the forwarded
  // value so a producer retiring during the stall is kept; without forwarding
  // this degenerates to a plain hold.
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET: begin
        valid_r       <= 1'b0;
        rs_val_r      <= '0;
        rt_val_r      <= '0;
        rs_addr_r     <= '0;
        rt_addr_r     <= '0;
        rd_r          <= '0;
        shamt_r       <= 5'd0;
        imm_r         <= 16'd0;
        alu_fun_r     <= '0;
        shamt_src_r   <= 1'b0;
        alu_src_imm_r <= 1'b0;
        ext_op_r      <= 1'b0;
        reg_write_r   <= 1'b0;
      end
      ACT_FLUSH: begin
        valid_r     <= 1'b0;
        reg_write_r <= 1'b0;
      end
      ACT_STALL: begin
        rs_val_r <= fwd_rs;
        rt_val_r <= fwd_rt;
      end
      ACT_LOAD: begin
        valid_r       <= id_valid;
        rs_val_r      <= id_rs_data;
        rt_val_r      <= id_rt_data;
        rs_addr_r     <= id_rs_addr;
        rt_addr_r     <= id_rt_addr;
        rd_r          <= id_rd_addr;
        shamt_r       <= id_shamt;
        imm_r         <= id_imm;
        alu_fun_r     <= id_alu_fun;
        shamt_src_r   <= id_shamt_src;
        alu_src_imm_r <= id_alu_src_imm;
        ext_op_r      <= id_ext_op;
        reg_write_r   <= id_reg_write;
      end
      default: begin
        valid_r     <= 1'b0;
        reg_write_r <= 1'b0;
      end
    endcase
  end

  id_ex_shift_operand_fwd_sel #(.W(W), .RA_W(RA_W)) u_fwd_rs (
    .idx             (rs_addr_r),
    .regval          (rs_val_r),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (fwd_rs)
  );

  id_ex_shift_operand_fwd_sel #(.W(W), .RA_W(RA_W)) u_fwd_rt (
    .idx             (rt_addr_r),
    .regval          (rt_val_r),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (fwd_rt)
  );

  assign imm_ext   = {{(W-16){ext_op_r & imm_r[15]}}, imm_r};
  assign shift_grp = is_shift(alu_fun_r[5:0]);

  // Only A[4:0] matters to the shifter, so the shamt path is zero-extended.
  assign ex_a         = shamt_src_r ? {{(W-5){1'b0}}, shamt_r} : fwd_rs;
  assign ex_b         = alu_src_imm_r ? imm_ext : fwd_rt;
  assign ex_right     = shift_grp & alu_fun_r[0];
  assign ex_sign      = shift_grp & alu_fun_r[1];
  assign ex_valid     = valid_r;
  assign ex_alu_fun   = alu_fun_r;
  assign ex_rd        = rd_r;
  assign ex_reg_write = reg_write_r & valid_r;

endmodule

// File: tb/tb_id_ex_shift_operand.sv
// Directed self-checking bench for id_ex_shift_operand (default build and EX_FORWARD_EN build).
module tb_id_ex_shift_operand;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [15:0] id_imm;
  logic [5:0]  id_alu_fun;
  logic        id_shamt_src, id_alu_src_imm, id_ext_op, id_reg_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_right, ex_sign, ex_reg_write;
  logic [31:0] ex_a, ex_b;
  logic [5:0]  ex_alu_fun;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  id_ex_shift_operand dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_shamt(id_shamt),
    .id_imm(id_imm), .id_alu_fun(id_alu_fun), .id_shamt_src(id_shamt_src),
    .id_alu_src_imm(id_alu_src_imm), .id_ext_op(id_ext_op), .id_reg_write(id_reg_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_right(ex_right), .ex_sign(ex_sign),
    .ex_alu_fun(ex_alu_fun), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    id_valid = 1'b1; id_rs_data = 32'h1234; id_rt_data = 32'h5678;
    id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_rd_addr = 5'd3; id_shamt = 5'd9;
    id_imm = 16'h00AA; id_alu_fun = 6'b100011; id_shamt_src = 1'b1;
    id_alu_src_imm = 1'b0; id_ext_op = 1'b0; id_reg_write = 1'b1;
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;

    // Reset state
    tick; tick;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_a", ex_a, 32'd0);
    check("rst_b", ex_b, 32'd0);
    check("rst_right", {31'd0, ex_right}, 32'd0);
    check("rst_sign", {31'd0, ex_sign}, 32'd0);
    check("rst_fun", {26'd0, ex_alu_fun}, 32'd0);
    check("rst_rd", {27'd0, ex_rd}, 32'd0);
    check("rst_rw", {31'd0, ex_reg_write}, 32'd0);
    reset = 1'b0;

    // 1: sll by 4
    id_shamt = 5'd4; id_rt_data = 32'd24; id_shamt_src = 1'b1; id_alu_fun = 6'b100000;
    id_rs_addr = 5'd0; id_rt_addr = 5'd2; id_rd_addr = 5'd3;
    tick;
    check("sll_valid", {31'd0, ex_valid}, 32'd1);
    check("sll_a", ex_a, 32'd4);
    check("sll_b", ex_b, 32'd24);
    check("sll_right", {31'd0, ex_right}, 32'd0);
    check("sll_sign", {31'd0, ex_sign}, 32'd0);
    check("sll_fun", {26'd0, ex_alu_fun}, 32'h20);
    check("sll_rd", {27'd0, ex_rd}, 32'd3);
    check("sll_rw", {31'd0, ex_reg_write}, 32'd1);

    // 2: srav, EX/MEM beats MEM/WB
    id_alu_fun = 6'b100011; id_shamt_src = 1'b0; id_rs_addr = 5'd5; id_rs_data = 32'd1000;
    id_rt_addr = 5'd6; id_rt_data = 32'hF8A432EB;
    exmem_reg_write = 1'b1; exmem_rd = 5'd5; exmem_result = 32'd9;
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_result = 32'd7;
    tick;
    check("srav_a", ex_a, FWD ? 32'd9 : 32'd1000);
    check("srav_b", ex_b, 32'hF8A432EB);
    check("srav_right", {31'd0, ex_right}, 32'd1);
    check("srav_sign", {31'd0, ex_sign}, 32'd1);
    exmem_rd = 5'd7;
    #1;
    check("memwb_only_a", ex_a, FWD ? 32'd7 : 32'd1000);

    // 3: r0 never forwarded
    id_rs_addr = 5'd0; id_rs_data = 32'd0;
    exmem_rd = 5'd0; exmem_result = 32'd88888; memwb_rd = 5'd0; memwb_result = 32'd5;
    tick;
    check("r0_a", ex_a, 32'd0);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // srl: right without sign
    id_alu_fun = 6'b100001;
    tick;
    check("srl_right", {31'd0, ex_right}, 32'd1);
    check("srl_sign", {31'd0, ex_sign}, 32'd0);

    // 4: 3-cycle stall while rs producer drains
    id_rs_addr = 5'd4; id_rs_data = 32'd11; id_rd_addr = 5'd8;
    tick;
    check("pre_stall_a", ex_a, 32'd11);
    stall = 1'b1; id_rs_data = 32'd99; id_rd_addr = 5'd9;
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'd25;
    #1;
    check("stall0_a", ex_a, FWD ? 32'd25 : 32'd11);
    tick;
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'd25;
    #1;
    check("stall1_a", ex_a, FWD ? 32'd25 : 32'd11);
    tick;
    memwb_reg_write = 1'b0;
    #1;
    check("stall2_a", ex_a, FWD ? 32'd25 : 32'd11);
    tick;
    check("stall3_a", ex_a, FWD ? 32'd25 : 32'd11);
    check("stall_rd", {27'd0, ex_rd}, 32'd8);
    check("stall_valid", {31'd0, ex_valid}, 32'd1);

    // 5: flush wins over stall
    flush = 1'b1;
    tick;
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // 6: reset mid-stream
    id_shamt = 5'd7; id_shamt_src = 1'b1; id_rd_addr = 5'd12; id_alu_fun = 6'b100000;
    tick;
    check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    reset = 1'b1; stall = 1'b1;
    tick;
    check("mrst_valid", {31'd0, ex_valid}, 32'd0);
    check("mrst_a", ex_a, 32'd0);
    check("mrst_b", ex_b, 32'd0);
    check("mrst_rd", {27'd0, ex_rd}, 32'd0);
    reset = 1'b0; stall = 1'b0;
    tick;
    check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("post_rst_a", ex_a, 32'd7);
    check("post_rst_rd", {27'd0, ex_rd}, 32'd12);

    // 7: immediate extension
    id_alu_fun = 6'b001000; id_shamt_src = 1'b0; id_alu_src_imm = 1'b1;
    id_imm = 16'hFFFF; id_ext_op = 1'b1; id_rs_addr = 5'd1; id_rs_data = 32'd5;
    tick;
    check("imm_sext_b", ex_b, 32'hFFFFFFFF);
    check("imm_sext_a", ex_a, 32'd5);
    check("addi_right", {31'd0, ex_right}, 32'd0);
    id_ext_op = 1'b0;
    tick;
    check("imm_zext_b", ex_b, 32'h0000FFFF);

    // Invalid slot suppresses write enable
    id_valid = 1'b0; id_reg_write = 1'b1;
    tick;
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_rw", {31'd0, ex_reg_write}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
